i2s_tx: RTL and testbench

- Output end of the effect chain: accepts one mono sample per `vld_i` strobe from the last effect stage.
- Holds it in a one-deep buffer and serializes it to the audio DAC as a standard I2S stream.
- The same sample goes out in both left and right slots.
- Generates `bclk` and `lrclk` itself by dividing the system clock, and reports buffer underrun/overrun.

---
 rtl/i2s_tx.sv | 152 +++++++++++++++
 tb/tb_i2s_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample buffer, mono-to-stereo serializer,
// bclk/lrclk generated from the system clock.
module i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         vld_i,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         req_o,
    output logic                         underrun_o,
    output logic                         overrun_o
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_N = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_N = BIT_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  bclk_q, bclk_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  full_q, full_d;
    logic                  req_q, req_d;
    logic                  under_q, under_d;
    logic                  over_q, over_d;

    logic                  fall;
    logic                  load;
    logic [BIT_W-1:0]      slot_b;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        full_d    = full_q;
        req_d     = 1'b0;
        under_d   = 1'b0;
        over_d    = 1'b0;
        fall      = 1'b0;
        slot_b    = '0;
        shifted   = '0;

        if (div_cnt_q == DIV_TC) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            fall      = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        load = fall && (bit_cnt_q == BIT_TC);

        // A strobe on the load cycle bypasses the buffer entirely.
        if (load) begin
            req_d = 1'b1;
            if (vld_i) begin
                frame_d = data_i;
                full_d  = 1'b0;
            end else if (full_q) begin
                frame_d = hold_q;
                full_d  = 1'b0;
            end else begin
                under_d = 1'b1;
            end
        end else if (vld_i) begin
            hold_d = data_i;
            full_d = 1'b1;
            over_d = full_q;
        end

        if (fall) begin
            if (bit_cnt_q == BIT_TC) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
            lrclk_d = (bit_cnt_d >= SLOT_N);
            slot_b  = lrclk_d ? (bit_cnt_d - SLOT_N) : bit_cnt_d;
            sdata_d = 1'b0;
            if (slot_b != '0 && slot_b <= DATA_N) begin
                shifted = frame_d << (slot_b - BIT_W'(1));
                sdata_d = shifted[DATA_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_TC;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            frame_q   <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            req_q     <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
        end else if (!en) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_TC;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            frame_q   <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            req_q     <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            frame_q   <= frame_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            req_q     <= req_d;
            under_q   <= under_d;
            over_q    <= over_d;
        end
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign req_o      = req_q;
    assign underrun_o = under_q;
    assign overrun_o  = over_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle model built from frame/slot arithmetic,
// plus directed slot captures.
module tb_i2s_tx;

    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int DIV = 2;
    localparam int PER = 2 * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          vld = 1'b0;
    logic [DW-1:0] din = '0;
    logic          bclk, lrclk, sdata, req_o, underrun_o, overrun_o;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_i(din), .vld_i(vld),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .req_o(req_o),
        .underrun_o(underrun_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int k = 0;
    logic [DW-1:0] m_frame = '0;
    logic [DW-1:0] m_hold = '0;
    bit m_full = 0;
    bit e_req = 0, e_under = 0, e_over = 0;
    logic [DW-1:0] cap_l = '0, cap_r = '0;

    task automatic m_reset();
        k = 0;
        m_frame = '0;
        m_hold = '0;
        m_full = 0;
        e_req = 0;
        e_under = 0;
        e_over = 0;
    endtask

    task automatic m_edge();
        e_req = 0;
        e_under = 0;
        e_over = 0;
        if (!rst_n || !en) begin
            m_reset();
        end else begin
            k++;
            if (k % PER == 0 && ((k / PER - 1) % (2 * SW)) == 0) begin
                e_req = 1;
                if (vld) begin
                    m_frame = din;
                    m_full = 0;
                end else if (m_full) begin
                    m_frame = m_hold;
                    m_full = 0;
                end else begin
                    e_under = 1;
                end
            end else if (vld) begin
                e_over = m_full;
                m_hold = din;
                m_full = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        int f, bc, b;
        logic e_lr, e_sd;
        logic [DW-1:0] t;
        f = k / PER;
        e_lr = 1'b0;
        e_sd = 1'b0;
        if (f > 0) begin
            bc = (f - 1) % (2 * SW);
            b = bc % SW;
            e_lr = (bc >= SW);
            if (b >= 1 && b <= DW) begin
                t = m_frame >> (DW - b);
                e_sd = t[0];
            end
        end
        chk("bclk", DW'(bclk), DW'((k / DIV) % 2));
        chk("lrclk", DW'(lrclk), DW'(e_lr));
        chk("sdata", DW'(sdata), DW'(e_sd));
        chk("req", DW'(req_o), DW'(e_req));
        chk("underrun", DW'(underrun_o), DW'(e_under));
        chk("overrun", DW'(overrun_o), DW'(e_over));
    endtask

    task automatic capture();
        int f, bc, b;
        f = k / PER;
        if (rst_n && en && f > 0 && k % PER == DIV) begin
            bc = (f - 1) % (2 * SW);
            b = bc % SW;
            if (b >= 1 && b <= DW) begin
                if (bc < SW) cap_l = {cap_l[DW-2:0], sdata};
                else         cap_r = {cap_r[DW-2:0], sdata};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
        capture();
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        vld = 1'b1;
        din = d;
        step();
        vld = 1'b0;
    endtask

    task automatic goto_k(input int target);
        int guard;
        guard = 0;
        while (k != target && guard < 4000) begin
            step();
            guard++;
        end
        if (k != target) begin
            total++;
            bad++;
            $error("FAIL goto got=%0d exp=%0d", k, target);
        end
    endtask

    initial begin
        m_reset();
        #1;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;

        goto_k(4);
        chk("first_under", DW'(underrun_o), DW'(1));
        chk("first_req", DW'(req_o), DW'(1));

        goto_k(100);
        strobe(24'hA50F3C);
        goto_k(516);
        chk("basic_l", cap_l, 24'hA50F3C);
        chk("basic_r", cap_r, 24'hA50F3C);
        chk("repeat_under", DW'(underrun_o), DW'(1));

        goto_k(772);
        chk("repeat_l", cap_l, 24'hA50F3C);
        chk("repeat_r", cap_r, 24'hA50F3C);

        goto_k(800);
        strobe(24'h111111);
        chk("ovr_first", DW'(overrun_o), DW'(0));
        repeat (5) step();
        strobe(24'h800001);
        chk("ovr_second", DW'(overrun_o), DW'(1));

        goto_k(1283);
        chk("ovr_l", cap_l, 24'h800001);
        chk("ovr_r", cap_r, 24'h800001);
        strobe(24'h7FFFFF);
        chk("byp_req", DW'(req_o), DW'(1));
        chk("byp_under", DW'(underrun_o), DW'(0));
        chk("byp_ovr", DW'(overrun_o), DW'(0));

        goto_k(1540);
        chk("byp_l", cap_l, 24'h7FFFFF);
        chk("byp_r", cap_r, 24'h7FFFFF);
        chk("byp_empty", DW'(underrun_o), DW'(1));

        goto_k(1580);
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        goto_k(4);
        chk("rst_under", DW'(underrun_o), DW'(1));
        goto_k(260);
        chk("rst_zero", cap_l, 24'h0);

        goto_k(300);
        en = 1'b0;
        repeat (20) step();
        strobe(24'h5A5A5A);
        repeat (29) step();
        en = 1'b1;
        goto_k(4);
        chk("en_ignore", DW'(underrun_o), DW'(1));

        repeat (1100) begin
            if ($urandom_range(0, 39) == 0) begin
                vld = 1'b1;
                din = DW'($urandom);
            end else begin
                vld = 1'b0;
            end
            step();
        end
        vld = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
